// File: rtl/ns_inverse_ctrl_pkg.sv
// ns_inverse_ctrl_pkg
// Shared definitions for the Newton-Schulz inverse controller and the
// matrix multiplier it drives: FSM state encoding, Q4.12 fixed-point
// constants and the helper that locates a matrix entry in a flat bus.
package ns_inverse_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MUL1,
      WAIT1,
      SUB,
      MUL2,
      WAIT2,
      UPDATE,
      FIN
   } state_t;

   localparam logic signed [15:0] ONE  = 16'sd4096;
   localparam logic signed [15:0] TWO  = 16'sd8192;
   localparam int                 FRAC = 12;

   // Bit offset of entry (i,j), 1-based row/column, in a 144-bit
   // row-major flat matrix of 16-bit entries.
   function automatic int idx(input int i, input int j);
      return 16 * (3 * (i - 1) + (j - 1));
   endfunction

endpackage

// File: rtl/ns_inverse_ctrl_if.sv
// ns_inverse_ctrl_if
// Bundles the request/result signals of the controller together with the
// multiplier handshake it drives.
//   start, iters, a_flat, x0_flat : run request (user -> controller)
//   busy, done, x_flat            : status and result (controller -> user)
//   m_q_flat, m_p_flat, m_valid   : multiply request (controller -> multiplier)
//   m_done, m_r_flat              : multiply result (multiplier -> controller)
// The slave modport is the controller's view; master is everything around it.
interface ns_inverse_ctrl_if #(
   parameter int ITER_W = 4
);
   logic              start;
   logic [ITER_W-1:0] iters;
   logic [143:0]      a_flat;
   logic [143:0]      x0_flat;
   logic              busy;
   logic              done;
   logic [143:0]      x_flat;
   logic [143:0]      m_q_flat;
   logic [143:0]      m_p_flat;
   logic              m_valid;
   logic              m_done;
   logic [143:0]      m_r_flat;

   modport slave (
      input  start, iters, a_flat, x0_flat, m_done, m_r_flat,
      output busy, done, x_flat, m_q_flat, m_p_flat, m_valid
   );

   modport master (
      output start, iters, a_flat, x0_flat, m_done, m_r_flat,
      input  busy, done, x_flat, m_q_flat, m_p_flat, m_valid
   );
endinterface

// File: rtl/matrix_multiply1.sv
// matrix_multiply1
// 3x3 Q4.12 matrix multiplier, R = Q * P, with a fixed two-cycle latency:
// operands are captured on the edge that sees valid, and done pulses in the
// second cycle after the valid cycle with the product on r_flat.
//   clk, rst       : clock and asynchronous active-low reset
//   valid          : one-cycle request, captures q_flat/p_flat
//   q_flat, p_flat : left/right operands, row-major 16-bit signed entries
//   done, r_flat   : completion pulse and saturated Q4.12 product
module matrix_multiply1
   import ns_inverse_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         valid,
   input  logic [143:0] q_flat,
   input  logic [143:0] p_flat,
   output logic         done,
   output logic [143:0] r_flat
);

   logic [143:0] q_reg;
   logic [143:0] p_reg;
   logic         pending;
   logic [143:0] prod;

   // Capture operands on request, then publish the product one edge later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_reg   <= '0;
         p_reg   <= '0;
         pending <= 1'b0;
         done    <= 1'b0;
         r_flat  <= '0;
      end else begin
         pending <= valid;
         done    <= pending;
         if (valid) begin
            q_reg <= q_flat;
            p_reg <= p_flat;
         end
         if (pending)
            r_flat <= prod;
      end
   end

   // Dot products are accumulated at full precision, rescaled by an
   // arithmetic shift (floor) and clamped to the 16-bit signed range.
   always_comb begin
      logic signed [15:0] qe;
      logic signed [15:0] pe;
      logic signed [31:0] mul;
      logic signed [33:0] acc;
      logic signed [33:0] sh;
      prod = '0;
      qe   = '0;
      pe   = '0;
      mul  = '0;
      acc  = '0;
      sh   = '0;
      for (int i = 1; i <= 3; i++) begin
         for (int j = 1; j <= 3; j++) begin
            acc = '0;
            for (int k = 1; k <= 3; k++) begin
               qe  = q_reg[idx(i, k) +: 16];
               pe  = p_reg[idx(k, j) +: 16];
               mul = qe * pe;
               acc = acc + 34'(mul);
            end
            sh = acc >>> FRAC;
            if (sh > 34'sd32767)
               prod[idx(i, j) +: 16] = 16'h7fff;
            else if (sh < -34'sd32768)
               prod[idx(i, j) +: 16] = 16'h8000;
            else
               prod[idx(i, j) +: 16] = sh[15:0];
         end
      end
   end

endmodule

// File: rtl/ns_inverse_ctrl_sub.sv
// ns_inverse_ctrl_sub
// Purely combinational T = 2I - P on a 3x3 Q4.12 matrix.
//   p_flat : product P, row-major 16-bit signed entries
//   t_flat : 2I - P, each entry saturated to the 16-bit signed range
module ns_inverse_ctrl_sub
   import ns_inverse_ctrl_pkg::*;
(
   input  logic [143:0] p_flat,
   output logic [143:0] t_flat
);

   logic signed [15:0] pij;
   logic        [16:0] diff;

   // Each entry is worked in 17 bits so that 8192 - (-32768) cannot wrap;
   // a disagreement between the top two bits means the 16-bit result
   // overflowed and is clamped toward the sign of the true value.
   always_comb begin
      t_flat = '0;
      pij    = '0;
      diff   = '0;
      for (int i = 1; i <= 3; i++) begin
         for (int j = 1; j <= 3; j++) begin
            pij  = p_flat[idx(i, j) +: 16];
            diff = ((i == j) ? {TWO[15], TWO} : 17'd0) - {pij[15], pij};
            if (diff[16] != diff[15])
               t_flat[idx(i, j) +: 16] = diff[16] ? 16'h8000 : 16'h7fff;
            else
               t_flat[idx(i, j) +: 16] = diff[15:0];
         end
      end
   end

endmodule

// File: rtl/ns_inverse_ctrl.sv
// ns_inverse_ctrl
// Sequences an external 3x3 Q4.12 matrix multiplier to run N Newton-Schulz
// iterations X <- X * (2I - A*X) starting from X0. Contains no multipliers.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : ns_inverse_ctrl_if.slave (request, status, result, multiplier port)
module ns_inverse_ctrl
   import ns_inverse_ctrl_pkg::*;
#(
   parameter int ITER_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   ns_inverse_ctrl_if.slave bus
);

   state_t            state;
   state_t            nxt;
   logic [143:0]      a_reg;
   logic [143:0]      x_reg;
   logic [143:0]      p_reg;
   logic [143:0]      t_reg;
   logic [143:0]      t_comb;
   logic [ITER_W-1:0] cnt;

   logic              busy;
   logic              done;
   logic              m_valid;
   logic [143:0]      m_q;
   logic [143:0]      m_p;

   ns_inverse_ctrl_sub u_sub (
      .p_flat (p_reg),
      .t_flat (t_comb)
   );

   // State register plus the datapath registers. Each register only loads
   // in the state that owns it, so multiplier results arriving in any other
   // state are simply dropped. X0 is loaded into X at acceptance, which
   // makes the N=0 case fall straight through to FIN with x = X0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         a_reg <= '0;
         x_reg <= '0;
         p_reg <= '0;
         t_reg <= '0;
         cnt   <= '0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_reg <= bus.a_flat;
                  x_reg <= bus.x0_flat;
                  cnt   <= bus.iters;
               end
            end
            WAIT1: begin
               if (bus.m_done)
                  p_reg <= bus.m_r_flat;
            end
            SUB: begin
               t_reg <= t_comb;
            end
            WAIT2: begin
               if (bus.m_done)
                  x_reg <= bus.m_r_flat;
            end
            UPDATE: begin
               cnt <= cnt - ITER_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state and output decode. Operands stay on the bus for the whole
   // request/wait pair so the multiplier may sample them at any point.
   // UPDATE looks at cnt before its decrement lands, hence the compare to 1.
   always_comb begin
      nxt     = state;
      busy    = 1'b0;
      done    = 1'b0;
      m_valid = 1'b0;
      m_q     = '0;
      m_p     = '0;
      case (state)
         IDLE: begin
            if (bus.start)
               nxt = (bus.iters != '0) ? MUL1 : FIN;
         end
         MUL1: begin
            busy    = 1'b1;
            m_valid = 1'b1;
            m_q     = a_reg;
            m_p     = x_reg;
            nxt     = WAIT1;
         end
         WAIT1: begin
            busy = 1'b1;
            m_q  = a_reg;
            m_p  = x_reg;
            if (bus.m_done)
               nxt = SUB;
         end
         SUB: begin
            busy = 1'b1;
            nxt  = MUL2;
         end
         MUL2: begin
            busy    = 1'b1;
            m_valid = 1'b1;
            m_q     = x_reg;
            m_p     = t_reg;
            nxt     = WAIT2;
         end
         WAIT2: begin
            busy = 1'b1;
            m_q  = x_reg;
            m_p  = t_reg;
            if (bus.m_done)
               nxt = UPDATE;
         end
         UPDATE: begin
            busy = 1'b1;
            nxt  = (cnt != ITER_W'(1)) ? MUL1 : FIN;
         end
         FIN: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: begin
            nxt = IDLE;
         end
      endcase
   end

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.m_valid  = m_valid;
   assign bus.m_q_flat = m_q;
   assign bus.m_p_flat = m_p;
   assign bus.x_flat   = x_reg;

endmodule

// File: tb/tb_ns_inverse_ctrl.sv
// tb_ns_inverse_ctrl
// Drives ns_inverse_ctrl with matrix_multiply1 as its multiplier and checks
// results, timing and reset behaviour against a plain-arithmetic model of
// the Newton-Schulz iteration.
module tb_ns_inverse_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ns_inverse_ctrl_if #(.ITER_W(4)) bus ();

   ns_inverse_ctrl #(.ITER_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   matrix_multiply1 mult (
      .clk    (clk),
      .rst    (rst),
      .valid  (bus.m_valid),
      .q_flat (bus.m_q_flat),
      .p_flat (bus.m_p_flat),
      .done   (bus.m_done),
      .r_flat (bus.m_r_flat)
   );

   // Entry (r,c), 0-based, of a row-major flat matrix.
   function automatic int ent(input logic [143:0] m, input int r, input int c);
      logic signed [15:0] v;
      v = m[16 * (3 * r + c) +: 16];
      return int'(v);
   endfunction

   function automatic int sat16(input longint v);
      if (v > 32767)
         return 32767;
      if (v < -32768)
         return -32768;
      return int'(v);
   endfunction

   function automatic logic [143:0] diagM(input int v);
      logic [143:0] m;
      m = '0;
      for (int r = 0; r < 3; r++)
         m[16 * (4 * r) +: 16] = 16'(v);
      return m;
   endfunction

   function automatic logic [143:0] randM();
      logic [143:0] m;
      for (int r = 0; r < 9; r++)
         m[16 * r +: 16] = 16'(int'($urandom_range(0, 8192)) - 4096);
      return m;
   endfunction

   function automatic logic [143:0] mmul(input logic [143:0] a, input logic [143:0] b);
      logic [143:0] m;
      longint       s;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            s = 0;
            for (int k = 0; k < 3; k++)
               s += longint'(ent(a, r, k)) * longint'(ent(b, k, c));
            m[16 * (3 * r + c) +: 16] = 16'(sat16(s >>> 12));
         end
      end
      return m;
   endfunction

   function automatic logic [143:0] twoIMinus(input logic [143:0] p);
      logic [143:0] m;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            m[16 * (3 * r + c) +: 16] =
               16'(sat16(longint'((r == c) ? 8192 : 0) - longint'(ent(p, r, c))));
      return m;
   endfunction

   function automatic logic [143:0] nsModel(input logic [143:0] a, input logic [143:0] x0, input int n);
      logic [143:0] x;
      x = x0;
      for (int k = 0; k < n; k++)
         x = mmul(x, twoIMinus(mmul(a, x)));
      return x;
   endfunction

   task automatic checkOutput(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete run: start sampled at edge 0, then every cycle up to a
   // few past the expected done edge is observed; done must appear right
   // after edge 8N, exactly once, with 2N multiply requests and 8N busy
   // cycles.
   task automatic applyStimulus(input string tag, input logic [143:0] a,
                                input logic [143:0] x0, input int n);
      int           doneEdge;
      int           doneCount;
      int           validCount;
      int           busyCount;
      logic [143:0] expX;
      expX = nsModel(a, x0, n);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.iters   = 4'(n);
      bus.a_flat  = a;
      bus.x0_flat = x0;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      doneEdge   = -1;
      doneCount  = 0;
      validCount = 0;
      busyCount  = 0;
      for (int e = 0; e <= 8 * n + 3; e++) begin
         if (e > 0) begin
            @(posedge clk);
            #1;
         end
         if (bus.done) begin
            doneCount++;
            if (doneEdge < 0)
               doneEdge = e;
         end
         if (bus.m_valid)
            validCount++;
         if (bus.busy)
            busyCount++;
      end
      checkOutput({tag, "_done_edge"}, 144'(doneEdge), 144'(8 * n));
      checkOutput({tag, "_done_pulses"}, 144'(doneCount), 144'(1));
      checkOutput({tag, "_mvalid_pulses"}, 144'(validCount), 144'(2 * n));
      checkOutput({tag, "_busy_cycles"}, 144'(busyCount), 144'(8 * n));
      checkOutput({tag, "_x"}, bus.x_flat, expX);
      checkOutput({tag, "_idle_busy"}, 144'(bus.busy), 144'(0));
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, 144'(bus.busy), 144'(0));
      checkOutput({tag, "_done"}, 144'(bus.done), 144'(0));
      checkOutput({tag, "_mvalid"}, 144'(bus.m_valid), 144'(0));
      checkOutput({tag, "_x"}, bus.x_flat, 144'(0));
      checkOutput({tag, "_mq"}, bus.m_q_flat, 144'(0));
      checkOutput({tag, "_mp"}, bus.m_p_flat, 144'(0));
   endtask

   initial begin
      logic [143:0] eye;
      logic [143:0] ra;
      logic [143:0] rx;
      eye         = diagM(4096);
      rst         = 1'b0;
      bus.start   = 1'b0;
      bus.iters   = '0;
      bus.a_flat  = '0;
      bus.x0_flat = '0;

      repeat (2) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst = 1'b1;

      applyStimulus("identity_n3", eye, eye, 3);
      applyStimulus("diag_n1", diagM(8192), diagM(1024), 1);
      applyStimulus("n0_passthru", randM(), randM(), 0);
      applyStimulus("sat_n1", diagM(-32768), eye, 1);

      // Interrupted run: a second start lands in WAIT1, then reset is
      // pulsed while the controller is waiting on the second multiply.
      ra = diagM(6144);
      rx = diagM(2048);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.iters   = 4'd2;
      bus.a_flat  = ra;
      bus.x0_flat = rx;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      bus.start   = 1'b1;
      bus.a_flat  = randM();
      bus.x0_flat = randM();
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("wait2_busy", 144'(bus.busy), 144'(1));
      checkOutput("wait2_mq", bus.m_q_flat, rx);
      checkOutput("wait2_mp", bus.m_p_flat, twoIMinus(mmul(ra, rx)));
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkAllZero("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b1;
      checkAllZero("post_rst");
      applyStimulus("after_rst", diagM(8192), diagM(1024), 2);

      for (int t = 0; t < 4; t++) begin
         applyStimulus($sformatf("rand%0d", t), randM(), randM(), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
